// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged release of downstream reset domains with acknowledge timeout
module reset_sequencer #(
   parameter int NSTAGE   = 3,
   parameter int HOLD_CYC = 4,
   parameter int GAP_CYC  = 2,
   parameter int TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              irstn,
   input  logic              ireset,
   input  logic [NSTAGE-1:0] istage_ack,
   output logic [NSTAGE-1:0] orst_n,
   output logic [2:0]        ostage,
   output logic              odone,
   output logic              oerr
);

   // One counter serves the hold, gap and timeout intervals, so size it for the largest
   localparam int MAXAB = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int MAXV  = (MAXAB > TIMEOUT) ? MAXAB : TIMEOUT;
   localparam int CW    = (MAXV > 1) ? $clog2(MAXV) : 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
   localparam logic [2:0]    LAST_STG  = 3'(NSTAGE - 1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT,
      S_GAP,
      S_DONE,
      S_ERR
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [NSTAGE-1:0] r_rst_n;
   logic [2:0]        r_stage;
   logic              r_done;
   logic              r_err;

   logic              w_ack_sel;
   logic [NSTAGE-1:0] w_next_mask;

   // Pick the acknowledge of the awaited domain and the release mask of the following one
   always_comb begin
      w_ack_sel   = 1'b0;
      w_next_mask = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         if (r_stage == 3'(k)) begin
            w_ack_sel = istage_ack[k];
         end
         if (r_stage + 3'd1 == 3'(k)) begin
            w_next_mask[k] = 1'b1;
         end
      end
   end

   // Sequencer FSM: hold all domains, then release one at a time waiting for each acknowledge
   always_ff @(posedge clk) begin
      if (!irstn || ireset) begin
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_rst_n <= '0;
         r_stage <= 3'd0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_rst_n[0] <= 1'b1;
                  r_stage    <= 3'd0;
                  r_cnt      <= '0;
                  r_state    <= S_WAIT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               // An acknowledge landing on the expiry edge still counts as success
               if (w_ack_sel) begin
                  if (r_stage == LAST_STG) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= S_GAP;
                  end
               end else if (r_cnt == TO_LAST) begin
                  r_err   <= 1'b1;
                  r_rst_n <= '0;
                  r_state <= S_ERR;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_rst_n <= r_rst_n | w_next_mask;
                  r_stage <= r_stage + 3'd1;
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_DONE;
            end
            S_ERR: begin
               r_state <= S_ERR;
            end
            default: begin
               r_state <= S_HOLD;
            end
         endcase
      end
   end

   assign orst_n = r_rst_n;
   assign ostage = r_stage;
   assign odone  = r_done;
   assign oerr   = r_err;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

   logic       clk;
   logic       irstn;
   logic       ireset;
   logic [2:0] istage_ack;
   logic [2:0] orst_n;
   logic [2:0] ostage;
   logic       odone;
   logic       oerr;

   int n_tests = 0;
   int n_fail  = 0;

   reset_sequencer #(
      .NSTAGE  (3),
      .HOLD_CYC(4),
      .GAP_CYC (2),
      .TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .irstn     (irstn),
      .ireset    (ireset),
      .istage_ack(istage_ack),
      .orst_n    (orst_n),
      .ostage    (ostage),
      .odone     (odone),
      .oerr      (oerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rst"},   32'(orst_n), 32'h0);
      check({tag, "_stage"}, 32'(ostage), 32'h0);
      check({tag, "_done"},  32'(odone),  32'h0);
      check({tag, "_err"},   32'(oerr),   32'h0);
   endtask

   // Eleven edges of a clean sequence; edge 1 is the first edge after the request is removed
   task automatic run_normal(input string tag);
      logic [2:0] er;
      logic [2:0] es;
      for (int e = 1; e <= 11; e++) begin
         tick();
         er = {(e >= 10) ? 1'b1 : 1'b0, (e >= 7) ? 1'b1 : 1'b0, (e >= 4) ? 1'b1 : 1'b0};
         es = (e >= 10) ? 3'd2 : ((e >= 7) ? 3'd1 : 3'd0);
         check($sformatf("%s_e%0d_rst", tag, e),   32'(orst_n), 32'(er));
         check($sformatf("%s_e%0d_stage", tag, e), 32'(ostage), 32'(es));
         check($sformatf("%s_e%0d_done", tag, e),  32'(odone),  (e >= 11) ? 32'h1 : 32'h0);
         check($sformatf("%s_e%0d_err", tag, e),   32'(oerr),   32'h0);
      end
   endtask

   initial begin
      irstn      = 1'b0;
      ireset     = 1'b0;
      istage_ack = 3'b111;

      // Power-on reset, then clean sequencing
      tick();
      tick();
      check_reset_vals("por");
      irstn = 1'b1;
      run_normal("norm");

      // DONE holds while acknowledges keep changing
      istage_ack = 3'b000;
      tick();
      tick();
      check("done_hold_done", 32'(odone), 32'h1);
      check("done_hold_rst", 32'(orst_n), 32'h7);

      // Re-request from DONE
      istage_ack = 3'b111;
      ireset = 1'b1;
      tick();
      check_reset_vals("rereq");
      ireset = 1'b0;
      run_normal("rereq");

      // Timeout on domain 1
      ireset = 1'b1;
      tick();
      ireset = 1'b0;
      istage_ack = 3'b101;
      for (int e = 1; e <= 22; e++) tick();
      check("to_e22_rst", 32'(orst_n), 32'h3);
      check("to_e22_err", 32'(oerr), 32'h0);
      check("to_e22_stage", 32'(ostage), 32'h1);
      tick();
      check("to_e23_err", 32'(oerr), 32'h1);
      check("to_e23_rst", 32'(orst_n), 32'h0);
      check("to_e23_done", 32'(odone), 32'h0);
      istage_ack = 3'b111;
      tick();
      tick();
      check("err_hold_err", 32'(oerr), 32'h1);
      check("err_hold_rst", 32'(orst_n), 32'h0);
      check("err_hold_done", 32'(odone), 32'h0);

      // irstn low during ERR
      irstn = 1'b0;
      tick();
      check_reset_vals("rst_in_err");
      irstn = 1'b1;

      // Held request in HOLD for 10 cycles
      ireset = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         check($sformatf("held_c%0d_rst", c), 32'(orst_n), 32'h0);
      end
      ireset = 1'b0;
      tick();
      tick();
      tick();
      check("held_e3_rst", 32'(orst_n), 32'h0);
      istage_ack = 3'b101;
      tick();
      check("held_e4_rst", 32'(orst_n), 32'h1);

      // Progress into WAIT(1) and then assert irstn
      tick();
      tick();
      tick();
      check("w1_rst", 32'(orst_n), 32'h3);
      check("w1_stage", 32'(ostage), 32'h1);
      irstn = 1'b0;
      tick();
      check_reset_vals("rst_in_w1");
      irstn = 1'b1;

      // Reach WAIT(2), then request and acknowledge on the same edge
      istage_ack = 3'b111;
      for (int e = 1; e <= 10; e++) tick();
      check("sim_pre_rst", 32'(orst_n), 32'h7);
      check("sim_pre_done", 32'(odone), 32'h0);
      ireset = 1'b1;
      tick();
      check("sim_done", 32'(odone), 32'h0);
      check("sim_rst", 32'(orst_n), 32'h0);
      ireset = 1'b0;
      tick();
      tick();
      tick();
      check("sim_e3_rst", 32'(orst_n), 32'h0);
      tick();
      check("sim_e4_rst", 32'(orst_n), 32'h1);
      check("sim_e4_done", 32'(odone), 32'h0);

      // Acknowledge arriving on the expiry edge wins
      irstn = 1'b0;
      tick();
      irstn = 1'b1;
      istage_ack = 3'b101;
      for (int e = 1; e <= 22; e++) tick();
      istage_ack = 3'b111;
      tick();
      check("tord_e23_err", 32'(oerr), 32'h0);
      check("tord_e23_rst", 32'(orst_n), 32'h3);
      tick();
      tick();
      check("tord_e25_rst", 32'(orst_n), 32'h7);
      check("tord_e25_stage", 32'(ostage), 32'h2);
      tick();
      check("tord_e26_done", 32'(odone), 32'h1);
      check("tord_e26_err", 32'(oerr), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
